// File: rtl/xmem_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the external-memory (MIG) slave port.
// Optional stall timeout with abort: define XMEM_ARB_TIMEOUT_EN.
module xmem_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [2:31] m0_adr_i,
    input  logic [0:31] m0_dat_i,
    input  logic [0:3]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [0:31] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [2:31] m1_adr_i,
    input  logic [0:31] m1_dat_i,
    input  logic [0:3]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [0:31] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [2:31] s_adr_o,
    output logic [0:31] s_dat_o,
    output logic [0:3]  s_sel_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [0:31] s_dat_i,
    input  logic        s_ack_i,

    output logic        timeout_flag,
    output logic [1:0]  state_o
);

    // Handshake: stb is "valid", s_ack_i is "ready"; a beat completes in a cycle where the
    // granted master's stb and s_ack_i are both high. cyc frames the grant across beats.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam logic [9:0] TIMEOUT_LIM = 10'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [2:31] adr_q;
    logic [0:31] dat_q;
    logic [0:3]  sel_q;
    logic        we_q;
    logic        timeout_hit;

    assign state_o = state_q;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        s_adr_o  = adr_q;
        s_dat_o  = dat_q;
        s_sel_o  = sel_q;
        s_we_o   = we_q;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_dat_o = '0;

        case (state_q)
            IDLE: begin
                // last_q == 1 means m1 was served most recently, so m0 wins a tie
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
                m1_dat_o = s_dat_i;
                if (timeout_hit) begin
                    state_d = ABORT;
                end else if (!m0_cyc_i) begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                m1_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
                m1_dat_o = s_dat_i;
                if (timeout_hit) begin
                    state_d = ABORT;
                end else if (!m1_cyc_i) begin
                    state_d = IDLE;
                end
            end
            ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capturing the driven slave fields every cycle keeps the last owner's values in IDLE/ABORT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            adr_q   <= s_adr_o;
            dat_q   <= s_dat_o;
            sel_q   <= s_sel_o;
            we_q    <= s_we_o;
        end
    end

`ifdef XMEM_ARB_TIMEOUT_EN
    logic [9:0] to_cnt_q, to_cnt_d;
    logic       stall;
    logic       flag_q;

    always_comb begin
        stall = ((state_q == GNT0) && m0_stb_i) || ((state_q == GNT1) && m1_stb_i);
        stall = stall && !s_ack_i;
        to_cnt_d    = stall ? (to_cnt_q + 10'd1) : 10'd0;
        timeout_hit = stall && (to_cnt_d == TIMEOUT_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            if (timeout_hit) begin
                flag_q <= 1'b1;
            end
        end
    end

    // last_q still names the aborted owner while in ABORT.
    assign m0_err_o     = (state_q == ABORT) && !last_q;
    assign m1_err_o     = (state_q == ABORT) && last_q;
    assign timeout_flag = flag_q;
`else
    logic [9:0] unused_timeout_lim;

    assign unused_timeout_lim = TIMEOUT_LIM;
    assign timeout_hit        = 1'b0;
    assign m0_err_o           = 1'b0;
    assign m1_err_o           = 1'b0;
    assign timeout_flag       = 1'b0;
`endif

endmodule

// File: tb/tb_xmem_arbiter.sv
// Randomized and directed bench for xmem_arbiter against a cycle-level ownership model.
// Builds with or without XMEM_ARB_TIMEOUT_EN; expectations follow the macro.
module tb_xmem_arbiter;

    localparam int TO = 8;
`ifdef XMEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:31] m0_adr, m1_adr, s_adr;
    logic [0:31] m0_wdat, m1_wdat, m0_rdat, m1_rdat, s_wdat, s_rdat;
    logic [0:3]  m0_sel, m1_sel, s_sel;
    logic        m0_we, m1_we, m0_stb, m1_stb, m0_cyc, m1_cyc;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic        s_we, s_stb, s_cyc, s_ack, timeout_flag;
    logic [1:0]  dbg_state;

    xmem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
        .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
        .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_dat_i(s_rdat), .s_ack_i(s_ack),
        .timeout_flag(timeout_flag), .state_o(dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] exp_q[$];

    int          mdl_owner;     // -1: nobody owns the slave
    int          mdl_last;
    int          mdl_run;
    bit          mdl_abort;
    int          mdl_abort_who;
    bit          mdl_flag;
    logic [2:31] h_adr;
    logic [0:31] h_dat;
    logic [0:3]  h_sel;
    logic        h_we;
    bit          cur_cyc[2];

    logic        obs_stb, obs_ack0, obs_ack1, obs_err0, obs_err1, obs_flag;
    logic [2:31] obs_adr;
    logic [0:31] obs_rdat0, obs_rdat1, obs_wdat;
    logic [0:3]  obs_sel;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_owner = -1; mdl_last = 1; mdl_run = 0;
        mdl_abort = 1'b0; mdl_abort_who = 0; mdl_flag = 1'b0;
        h_adr = '0; h_dat = '0; h_sel = '0; h_we = 1'b0;
    endtask

    task automatic sb_take(input logic [32:0] got);
        logic [32:0] e;
        check_eq("sb_pending", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("sb_resp", 64'(got), 64'(e));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_master(input int idx, input bit cyc, input bit stb, input bit we,
                              input logic [2:31] adr, input logic [0:31] dat, input logic [0:3] sel);
        if (idx == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_wdat = dat; m0_sel = sel;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_wdat = dat; m1_sel = sel;
        end
        cur_cyc[idx] = cyc;
    endtask

    task automatic check_zero(input string pfx);
        check_eq({pfx, "_s_cyc"}, 64'(s_cyc), 64'(0));
        check_eq({pfx, "_s_stb"}, 64'(s_stb), 64'(0));
        check_eq({pfx, "_s_adr"}, 64'(s_adr), 64'(0));
        check_eq({pfx, "_s_dat"}, 64'(s_wdat), 64'(0));
        check_eq({pfx, "_s_sel"}, 64'(s_sel), 64'(0));
        check_eq({pfx, "_s_we"}, 64'(s_we), 64'(0));
        check_eq({pfx, "_m0_ack"}, 64'(m0_ack), 64'(0));
        check_eq({pfx, "_m1_ack"}, 64'(m1_ack), 64'(0));
        check_eq({pfx, "_m0_err"}, 64'(m0_err), 64'(0));
        check_eq({pfx, "_m1_err"}, 64'(m1_err), 64'(0));
        check_eq({pfx, "_m0_dat"}, 64'(m0_rdat), 64'(0));
        check_eq({pfx, "_m1_dat"}, 64'(m1_rdat), 64'(0));
        check_eq({pfx, "_flag"}, 64'(timeout_flag), 64'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_master(0, 0, 0, 0, '0, '0, '0);
        set_master(1, 0, 0, 0, '0, '0, '0);
        s_ack = 1'b0;
        s_rdat = 32'h1234_5678;
        model_reset();
        @(posedge clk); #1;
        check_zero("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One clock: compare outputs at negedge with the model, then advance the model.
    task automatic cycle();
        logic [2:31] e_adr;
        logic [0:31] e_wdat, e_rdat;
        logic [0:3]  e_sel;
        logic        e_we, e_stb, e_cyc, e_ack0, e_ack1, own_cyc;
        int          nxt;
        @(negedge clk);
        case (mdl_owner)
            0: begin e_cyc = m0_cyc; e_stb = m0_stb; e_adr = m0_adr; e_wdat = m0_wdat; e_sel = m0_sel; e_we = m0_we; end
            1: begin e_cyc = m1_cyc; e_stb = m1_stb; e_adr = m1_adr; e_wdat = m1_wdat; e_sel = m1_sel; e_we = m1_we; end
            default: begin e_cyc = 0; e_stb = 0; e_adr = h_adr; e_wdat = h_dat; e_sel = h_sel; e_we = h_we; end
        endcase
        e_ack0 = (mdl_owner == 0) && s_ack;
        e_ack1 = (mdl_owner == 1) && s_ack;
        e_rdat = (mdl_owner >= 0) ? s_rdat : 32'h0;
        check_eq("s_cyc", 64'(s_cyc), 64'(e_cyc));
        check_eq("s_stb", 64'(s_stb), 64'(e_stb));
        check_eq("s_adr", 64'(s_adr), 64'(e_adr));
        check_eq("s_dat", 64'(s_wdat), 64'(e_wdat));
        check_eq("s_sel", 64'(s_sel), 64'(e_sel));
        check_eq("s_we", 64'(s_we), 64'(e_we));
        check_eq("m0_ack", 64'(m0_ack), 64'(e_ack0));
        check_eq("m1_ack", 64'(m1_ack), 64'(e_ack1));
        check_eq("m0_dat", 64'(m0_rdat), 64'(e_rdat));
        check_eq("m1_dat", 64'(m1_rdat), 64'(e_rdat));
        check_eq("m0_err", 64'(m0_err), 64'(mdl_abort && mdl_abort_who == 0));
        check_eq("m1_err", 64'(m1_err), 64'(mdl_abort && mdl_abort_who == 1));
        check_eq("flag", 64'(timeout_flag), 64'(mdl_flag));
        if (e_ack0) exp_q.push_back({1'b0, s_rdat});
        if (e_ack1) exp_q.push_back({1'b1, s_rdat});
        if (m0_ack) sb_take({1'b0, m0_rdat});
        if (m1_ack) sb_take({1'b1, m1_rdat});
        obs_stb = s_stb; obs_ack0 = m0_ack; obs_ack1 = m1_ack; obs_err0 = m0_err; obs_err1 = m1_err;
        obs_flag = timeout_flag; obs_adr = s_adr; obs_rdat0 = m0_rdat; obs_rdat1 = m1_rdat;
        obs_wdat = s_wdat; obs_sel = s_sel;

        if (mdl_owner >= 0) begin
            h_adr = e_adr; h_dat = e_wdat; h_sel = e_sel; h_we = e_we;
        end
        if (mdl_abort) begin
            mdl_abort = 1'b0;
        end else if (mdl_owner < 0) begin
            if (m0_cyc && m1_cyc) nxt = 1 - mdl_last;
            else if (m0_cyc)      nxt = 0;
            else if (m1_cyc)      nxt = 1;
            else                  nxt = -1;
            if (nxt >= 0) begin
                mdl_owner = nxt;
                mdl_last  = nxt;
            end
        end else begin
            own_cyc = (mdl_owner == 0) ? m0_cyc : m1_cyc;
            mdl_run = (e_stb && !s_ack) ? mdl_run + 1 : 0;
            if (TO_EN && mdl_run == TO) begin
                mdl_abort = 1'b1; mdl_abort_who = mdl_owner; mdl_flag = 1'b1;
                mdl_owner = -1; mdl_run = 0;
            end else if (!own_cyc) begin
                mdl_owner = -1; mdl_run = 0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic rand_master(input int idx, input logic ack, input logic err);
        bit c, st;
        if (!cur_cyc[idx]) c = ($urandom_range(0, 3) == 0);
        else if (err || (ack && $urandom_range(0, 2) == 0) || $urandom_range(0, 15) == 0) c = 1'b0;
        else c = 1'b1;
        st = c && ($urandom_range(0, 3) != 0);
        set_master(idx, c, st, $urandom_range(0, 1) == 1, 30'($urandom()), $urandom(),
                   4'($urandom_range(0, 15)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int acks0, errs, stbs, beats, quiet, mode;
        do_reset();

        // single m0 read, ack on the third granted cycle
        set_master(0, 1, 1, 0, 30'h0000_1000, 32'h0, 4'hF);
        cycle(); check_eq("t1_stb_c0", 64'(obs_stb), 64'(0));
        cycle(); check_eq("t1_stb_c1", 64'(obs_stb), 64'(1));
        check_eq("t1_adr", 64'(obs_adr), 64'(30'h0000_1000));
        cycle();
        s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
        cycle();
        check_eq("t1_ack0", 64'(obs_ack0), 64'(1));
        check_eq("t1_rdat0", 64'(obs_rdat0), 64'(32'hDEAD_BEEF));
        check_eq("t1_ack1", 64'(obs_ack1), 64'(0));
        s_ack = 1'b0;
        set_master(0, 0, 0, 0, '0, '0, '0);
        cycle(); cycle();

        // simultaneous contention after reset, then alternation
        do_reset();
        set_master(0, 1, 1, 0, 30'h111, 32'h0, 4'hF);
        set_master(1, 1, 1, 0, 30'h222, 32'h0, 4'hF);
        cycle();
        s_ack = 1'b1;
        cycle();
        check_eq("t2_first_m0", 64'(obs_adr), 64'(30'h111));
        check_eq("t2_ack0", 64'(obs_ack0), 64'(1));
        s_ack = 1'b0;
        set_master(0, 0, 0, 0, '0, '0, '0);
        cycle(); check_eq("t2_drop_stb", 64'(obs_stb), 64'(0));
        cycle(); check_eq("t2_dead_stb", 64'(obs_stb), 64'(0));
        s_ack = 1'b1;
        cycle();
        check_eq("t2_m1_stb", 64'(obs_stb), 64'(1));
        check_eq("t2_m1_adr", 64'(obs_adr), 64'(30'h222));
        check_eq("t2_ack1", 64'(obs_ack1), 64'(1));
        s_ack = 1'b0;
        set_master(1, 0, 0, 0, '0, '0, '0);
        cycle(); cycle();
        set_master(0, 1, 1, 0, 30'h333, 32'h0, 4'hF);
        set_master(1, 1, 1, 0, 30'h444, 32'h0, 4'hF);
        cycle(); s_ack = 1'b1; cycle();
        check_eq("t2b_m0", 64'(obs_adr), 64'(30'h333));
        s_ack = 1'b0;
        set_master(0, 0, 0, 0, '0, '0, '0);
        set_master(1, 0, 0, 0, '0, '0, '0);
        cycle(); cycle();
        set_master(0, 1, 1, 0, 30'h333, 32'h0, 4'hF);
        set_master(1, 1, 1, 0, 30'h444, 32'h0, 4'hF);
        cycle(); s_ack = 1'b1; cycle();
        check_eq("t2c_m1_first", 64'(obs_adr), 64'(30'h444));
        check_eq("t2c_ack0", 64'(obs_ack0), 64'(0));
        s_ack = 1'b0;
        set_master(0, 0, 0, 0, '0, '0, '0);
        set_master(1, 0, 0, 0, '0, '0, '0);
        cycle(); cycle();

        // m1 4-beat locked write burst while m0 requests continuously
        set_master(1, 1, 1, 1, 30'h500, 32'hB000_0000, 4'h1);
        cycle();
        set_master(0, 1, 1, 0, 30'h666, 32'h0, 4'hF);
        beats = 0; acks0 = 0; quiet = 0;
        for (int i = 0; i < 60 && beats < 4; i++) begin
            s_ack = ($urandom_range(0, 1) == 1) || (quiet >= 3);
            quiet = s_ack ? 0 : quiet + 1;
            s_rdat = $urandom();
            cycle();
            acks0 += int'(obs_ack0);
            if (obs_ack1) begin
                check_eq("t3_beat_dat", 64'(obs_wdat), 64'(32'hB000_0000 + beats));
                check_eq("t3_beat_sel", 64'(obs_sel), 64'(beats + 1));
                beats++;
                set_master(1, 1, 1, 1, 30'(30'h500 + beats), 32'hB000_0000 + beats, 4'(beats + 1));
            end
        end
        check_eq("t3_beats", 64'(beats), 64'(4));
        check_eq("t3_m0_noack", 64'(acks0), 64'(0));
        s_ack = 1'b0;
        set_master(1, 0, 0, 0, '0, '0, '0);
        cycle(); cycle(); cycle();
        check_eq("t3_m0_gnt", 64'(obs_adr), 64'(30'h666));
        check_eq("t3_m0_stb", 64'(obs_stb), 64'(1));
        s_ack = 1'b1; cycle();
        s_ack = 1'b0;
        set_master(0, 0, 0, 0, '0, '0, '0);
        cycle(); cycle();

        // asynchronous reset in the middle of an m1 beat
        set_master(1, 1, 1, 1, 30'h777, 32'hCAFE_F00D, 4'hC);
        cycle(); cycle();
        check_eq("t4_gnt1", 64'(obs_stb), 64'(1));
        #2 rst_n = 1'b0;
        #1 check_zero("t4");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_master(0, 1, 1, 0, 30'h888, 32'h0, 4'hF);
        set_master(1, 1, 1, 0, 30'h999, 32'h0, 4'hF);
        cycle(); cycle();
        check_eq("t4_m0_after_rst", 64'(obs_adr), 64'(30'h888));
        set_master(0, 0, 0, 0, '0, '0, '0);
        set_master(1, 0, 0, 0, '0, '0, '0);
        cycle(); cycle();

        // unresponsive slave on an m0 request
        set_master(0, 1, 1, 0, 30'h555, 32'h0, 4'hF);
        s_ack = 1'b0;
        errs = 0; stbs = 0;
        for (int i = 0; i < TO + 8; i++) begin
            cycle();
            errs += int'(obs_err0);
            stbs += int'(obs_stb);
            if (obs_err0) set_master(0, 0, 0, 0, '0, '0, '0);
        end
        check_eq("t5_err_pulses", 64'(errs), TO_EN ? 64'(1) : 64'(0));
        check_eq("t5_flag", 64'(obs_flag), TO_EN ? 64'(1) : 64'(0));
        check_eq("t5_stb_cycles", 64'(stbs), TO_EN ? 64'(TO) : 64'(TO + 7));
        check_eq("t5_stb_last", 64'(obs_stb), TO_EN ? 64'(0) : 64'(1));
        set_master(0, 0, 0, 0, '0, '0, '0);
        cycle(); cycle();
        set_master(1, 1, 1, 0, 30'h0AA, 32'h0, 4'h3);
        cycle();
        s_ack = 1'b1; s_rdat = 32'h600D_0001;
        cycle();
        check_eq("t5_m1_ack", 64'(obs_ack1), 64'(1));
        check_eq("t5_m1_dat", 64'(obs_rdat1), 64'(32'h600D_0001));
        s_ack = 1'b0;
        set_master(1, 0, 0, 0, '0, '0, '0);
        cycle(); cycle();

        // randomized traffic, including stretches of a silent slave
        mode = 1;
        for (int i = 0; i < 2000; i++) begin
            if (i % 64 == 0) mode = $urandom_range(0, 3);
            s_ack  = (mode == 0) ? 1'b0 : ($urandom_range(0, mode) != 0);
            s_rdat = $urandom();
            rand_master(0, obs_ack0, obs_err0);
            rand_master(1, obs_ack1, obs_err1);
            cycle();
        end

        check_eq("sb_drain", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
